// File: rtl/ah_pkg.sv
// ah_pkg: shared definitions for the Nios summing accelerator blocks
// (sum unit, go-latch and read master wrappers).
//   state_t      : sum unit FSM states
//   LEN_W        : width of the byte-length field programmed by Nios
//   DATA_W_DEF   : default buffer word width
//   ACC_W_DEF    : default accumulator / result width
//   words_of()   : byte length -> 16-bit word count (odd trailing byte dropped)
package ah_pkg;

  localparam int LEN_W      = 22;
  localparam int DATA_W_DEF = 16;
  localparam int ACC_W_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT,
    DONE
  } state_t;

  // Result is kept LEN_W wide so every bit of the length field is consumed.
  function automatic logic [LEN_W-1:0] words_of(input logic [LEN_W-1:0] len);
    return len >> 1;
  endfunction

endpackage

// File: rtl/ah_sum_datapath.sv
// ah_sum_datapath: word extension, adder, overflow detection and the
// accumulator register for the summing unit.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero acc and overflow (takes priority over add)
//   add        : acc += ext(data), overflow accumulates stickily
//   data       : buffer word to add
//   acc        : running sum, wraps modulo 2^ACC_W
//   overflow   : sticky overflow since the last clear
module ah_sum_datapath #(
  parameter int DATA_W      = 16,
  parameter int ACC_W       = 32,
  parameter int SIGNED_DATA = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              add,
  input  logic [DATA_W-1:0] data,
  output logic [ACC_W-1:0]  acc,
  output logic              overflow
);

  logic [ACC_W-1:0] ext;
  logic [ACC_W:0]   sum_w;
  logic             ovf_step;

  always_comb begin
    ext = '0;
    if (SIGNED_DATA != 0)
      ext = {{(ACC_W-DATA_W){data[DATA_W-1]}}, data};
    else
      ext = {{(ACC_W-DATA_W){1'b0}}, data};
  end

  assign sum_w = {1'b0, acc} + {1'b0, ext};

  always_comb begin
    ovf_step = 1'b0;
    if (SIGNED_DATA != 0)
      ovf_step = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum_w[ACC_W-1] != acc[ACC_W-1]);
    else
      ovf_step = sum_w[ACC_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (add) begin
      acc      <= sum_w[ACC_W-1:0];
      overflow <= overflow | ovf_step;
    end
  end

endmodule

// File: rtl/ah_sum_unit.sv
// ah_sum_unit: pops words from the read master's show-ahead FIFO, sums them
// and pulses sum_done once the word count is consumed and the master is done.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : one-cycle request pulse (ignored outside IDLE)
//   length         : transfer length in bytes, sampled on start
//   buffer_data    : FIFO head word, valid while data_available=1
//   data_available : FIFO non-empty
//   read_buffer    : combinational pop strobe
//   master_done    : read master completion (level or pulse)
//   sum_result     : last completed sum, held until the next completion
//   sum_done       : one-cycle pulse coincident with a new sum_result
//   busy           : high in every state except IDLE
//   overflow       : sticky overflow of the last/current sum
module ah_sum_unit
  import ah_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int SIGNED_DATA = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] buffer_data,
  input  logic              data_available,
  output logic              read_buffer,
  input  logic              master_done,
  output logic [ACC_W-1:0]  sum_result,
  output logic              sum_done,
  output logic              busy,
  output logic              overflow
);

  state_t           state, state_next;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] words;
  logic             done_seen;
  logic             acc_clear;
  logic             acc_add;
  logic             load_result;
  logic [ACC_W-1:0] acc;

  assign words = words_of(length);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    read_buffer = 1'b0;
    acc_clear   = 1'b0;
    acc_add     = 1'b0;
    load_result = 1'b0;
    sum_done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          acc_clear  = 1'b1;
          state_next = (words == '0) ? WAIT : RUN;
        end
      end
      RUN: begin
        read_buffer = data_available && (remaining != '0);
        acc_add     = read_buffer;
        if (read_buffer && (remaining == LEN_W'(1)))
          state_next = WAIT;
      end
      WAIT: begin
        if (done_seen || master_done) begin
          load_result = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: begin
        sum_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      done_seen <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        remaining <= words;
        done_seen <= 1'b0;
      end else if (state == RUN) begin
        if (read_buffer) remaining <= remaining - LEN_W'(1);
        if (master_done) done_seen <= 1'b1;
      end
    end
  end

  // Result is captured on the WAIT->DONE edge so the new value is already
  // visible during the DONE cycle, coincident with sum_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           sum_result <= '0;
    else if (load_result) sum_result <= acc;
  end

  ah_sum_datapath #(
    .DATA_W      (DATA_W),
    .ACC_W       (ACC_W),
    .SIGNED_DATA (SIGNED_DATA)
  ) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (acc_clear),
    .add      (acc_add),
    .data     (buffer_data),
    .acc      (acc),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_ah_sum_unit.sv
// Bench for ah_sum_unit: three instances (32-bit unsigned, 17-bit unsigned,
// 32-bit signed) share one stimulus stream and one FIFO model.
module tb_ah_sum_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [21:0] length;
  logic [15:0] buffer_data;
  logic        data_available;
  logic        master_done;

  logic        rb0, rb1, rb2, sd0, sd1, sd2, bz0, bz1, bz2, ov0, ov1, ov2;
  logic [31:0] sr0, sr2;
  logic [16:0] sr1;

  always #5 clk = ~clk;

  ah_sum_unit u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .length(length),
    .buffer_data(buffer_data), .data_available(data_available),
    .read_buffer(rb0), .master_done(master_done), .sum_result(sr0),
    .sum_done(sd0), .busy(bz0), .overflow(ov0));

  ah_sum_unit #(.ACC_W(17), .SIGNED_DATA(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .length(length),
    .buffer_data(buffer_data), .data_available(data_available),
    .read_buffer(rb1), .master_done(master_done), .sum_result(sr1),
    .sum_done(sd1), .busy(bz1), .overflow(ov1));

  ah_sum_unit #(.ACC_W(32), .SIGNED_DATA(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .length(length),
    .buffer_data(buffer_data), .data_available(data_available),
    .read_buffer(rb2), .master_done(master_done), .sum_result(sr2),
    .sum_done(sd2), .busy(bz2), .overflow(ov2));

  int checks   = 0;
  int failures = 0;

  logic [15:0] q[$];   // FIFO contents as the DUT sees them
  logic [15:0] wd[$];  // words belonging to the current transfer

  typedef struct {
    int          len;
    int          mode;      // 0 always available, 1 toggling, 2 random
    int          md_off;    // cycle (after start) of the master_done pulse
    int          mid_start; // cycle of an extra start pulse, -1 none
    int          n_extra;   // words left in the FIFO beyond the transfer
    logic [15:0] w[4];
    logic [31:0] e0;
    logic [16:0] e1;
    logic        e1ov;
    logic [31:0] e2;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input int len, input int mode, input int md_off,
                         input int mid_start, input int n_extra,
                         input logic [31:0] e0, input logic e0ov,
                         input logic [16:0] e1, input logic e1ov,
                         input logic [31:0] e2, input logic e2ov);
    int   words;
    int   mpops;
    int   t_ready;
    int   exp_done;
    bit   fin;
    logic avail;
    logic exp_rb;
    words    = len / 2;
    mpops    = 0;
    t_ready  = -1;
    exp_done = -1;
    fin      = 1'b0;
    q.delete();
    foreach (wd[i]) q.push_back(wd[i]);
    for (int i = 0; i < n_extra; i++) q.push_back(16'h0099 + 16'(i));
    for (int k = 0; k < 400 && !fin; k++) begin
      @(negedge clk);
      start       = (k == 0) || (k == mid_start);
      length      = (k == 0) ? 22'(len) : 22'd40;
      master_done = (k == md_off);
      if (q.size() == 0) avail = 1'b0;
      else if (mode == 0) avail = 1'b1;
      else if (mode == 1) avail = (k % 2) == 1;
      else avail = $urandom_range(0, 3) != 0;
      data_available = avail;
      buffer_data    = (q.size() > 0) ? q[0] : 16'hDEAD;
      #1;
      exp_rb = (k >= 1) && avail && (mpops < words);
      check("read_buffer", 64'(rb0), 64'(exp_rb));
      if (rb0 === 1'b1 && q.size() > 0) void'(q.pop_front());
      if (exp_rb) begin
        mpops++;
        if (mpops == words) t_ready = k + 1;
      end
      if (words == 0 && k == 0) t_ready = 1;
      if (t_ready >= 0 && exp_done < 0)
        exp_done = ((t_ready > md_off) ? t_ready : md_off) + 1;
      check("sum_done", 64'(sd0), 64'(k == exp_done));
      check("busy", 64'(bz0), 64'((k >= 1) && (exp_done < 0 || k <= exp_done)));
      if (k == exp_done) begin
        check("sum_result_u32", 64'(sr0), 64'(e0));
        check("overflow_u32", 64'(ov0), 64'(e0ov));
        check("sum_result_u17", 64'(sr1), 64'(e1));
        check("overflow_u17", 64'(ov1), 64'(e1ov));
        check("sum_result_s32", 64'(sr2), 64'(e2));
        check("overflow_s32", 64'(ov2), 64'(e2ov));
        check("sum_done_all", 64'({sd1, sd2}), 64'(2'b11));
      end
      if (exp_done >= 0 && k == exp_done + 1) begin
        check("sum_result_held", 64'(sr0), 64'(e0));
        check("fifo_leftover", 64'(q.size()), 64'(n_extra));
        fin = 1'b1;
      end
    end
    if (!fin) check("completion_timeout", 64'(0), 64'(1));
  endtask

  // Reference: plain integer sums; overflow judged on the exact partial sums.
  task automatic model(output logic [31:0] e0, output logic e0ov,
                       output logic [16:0] e1, output logic e1ov,
                       output logic [31:0] e2, output logic e2ov);
    longint t;
    longint s;
    t    = 0;
    s    = 0;
    e2ov = 1'b0;
    foreach (wd[i]) begin
      t += longint'(wd[i]);
      s += longint'($signed(wd[i]));
      if (s > 64'sd2147483647 || s < -64'sd2147483648) e2ov = 1'b1;
    end
    e0   = t[31:0];
    e0ov = t >= 64'sd4294967296;
    e1   = t[16:0];
    e1ov = t >= 64'sd131072;
    e2   = s[31:0];
  endtask

  initial begin
    tbl[0] = '{8, 0, 5, -1, 0, '{16'd1, 16'd2, 16'd3, 16'd4}, 32'd10, 17'd10, 1'b0, 32'd10};
    tbl[1] = '{7, 1, 30, -1, 1, '{16'h0010, 16'h0020, 16'h0030, 16'h0000},
               32'h60, 17'h60, 1'b0, 32'h60};
    tbl[2] = '{0, 0, 5, -1, 0, '{16'h0, 16'h0, 16'h0, 16'h0}, 32'h0, 17'h0, 1'b0, 32'h0};
    tbl[3] = '{4, 0, 1, -1, 0, '{16'hFFFF, 16'hFFFF, 16'h0, 16'h0},
               32'h1FFFE, 17'h1FFFE, 1'b0, 32'hFFFFFFFE};
    tbl[4] = '{6, 0, 2, -1, 0, '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0},
               32'h2FFFD, 17'h0FFFD, 1'b1, 32'hFFFFFFFD};
    tbl[5] = '{4, 2, 3, -1, 0, '{16'hFFFF, 16'h0003, 16'h0, 16'h0},
               32'h10002, 17'h10002, 1'b0, 32'h2};
    tbl[6] = '{8, 1, 2, 4, 0, '{16'd5, 16'd6, 16'd7, 16'd8}, 32'd26, 17'd26, 1'b0, 32'd26};

    rst_n = 1'b0; start = 1'b0; length = '0; buffer_data = '0;
    data_available = 1'b0; master_done = 1'b0;
    #2;
    check("reset_sum_result", 64'({sr0, sr1, sr2}), 64'(0));
    check("reset_outputs", 64'({rb0, sd0, bz0, ov0, ov1, ov2}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      wd.delete();
      for (int i = 0; i < tbl[v].len / 2; i++) wd.push_back(tbl[v].w[i]);
      run_txn(tbl[v].len, tbl[v].mode, tbl[v].md_off, tbl[v].mid_start, tbl[v].n_extra,
              tbl[v].e0, 1'b0, tbl[v].e1, tbl[v].e1ov, tbl[v].e2, 1'b0);
    end

    // Reset in the middle of a long transfer, then a clean transfer.
    @(negedge clk);
    start = 1'b1; length = 22'd40; master_done = 1'b0;
    data_available = 1'b1; buffer_data = 16'h1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midrun_reset_sum", 64'({sr0, sr1, sr2}), 64'(0));
    check("midrun_reset_ctrl", 64'({rb0, sd0, bz0, ov0, ov1, ov2}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    data_available = 1'b0;
    wd.delete();
    for (int i = 0; i < 4; i++) wd.push_back(tbl[0].w[i]);
    run_txn(8, 0, 5, -1, 0, 32'd10, 1'b0, 17'd10, 1'b0, 32'd10, 1'b0);

    for (int r = 0; r < 25; r++) begin
      logic [31:0] e0, e2;
      logic [16:0] e1;
      logic        e0ov, e1ov, e2ov;
      int          nw;
      nw = $urandom_range(0, 10);
      wd.delete();
      for (int i = 0; i < nw; i++)
        wd.push_back(($urandom_range(0, 1) == 1) ? 16'hFFFF - 16'($urandom_range(0, 7))
                                                 : 16'($urandom));
      model(e0, e0ov, e1, e1ov, e2, e2ov);
      run_txn(nw * 2 + $urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(1, 25),
              -1, $urandom_range(0, 2), e0, e0ov, e1, e1ov, e2, e2ov);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
